gbpt_update_scheduler: RTL and testbench
========================================

// Module: gbpt_update_scheduler
// PURPOSE
//  Buffers branch-outcome updates from commit and schedules them onto the gbpt update port.
//  gbpt SRAM banks are single-ported: a cycle can carry a fetch read or an update, never both.
//  Fetch reads have priority; updates drain in idle read cycles.
//  A starvation counter or a full queue with a waiting enqueue forces one read-stall cycle so an update drains.
// PARAMETERS
//  DEPTH       4   update queue entries (power of 2, >=2)
//  STARVE_MAX  8   consecutive denied-drain cycles before a forced drain (>=1)
// PORTS
//  CLK                    in   1    clock
//  nRST                   in   1    async active-low reset
//  enq_valid              in   1    commit presents a resolved conditional branch
//  enq_ready              out  1    queue can accept (= ~full)
//  enq_pc38               in   38   corep::PC38_t of branch
//  enq_gh                 in   9    corep::GH_t at prediction
//  enq_taken              in   1    resolved direction
//  fetch_read_req_valid   in   1    fetch wants a gbpt read this cycle
//  fetch_read_stall       out  1    fetch read refused this cycle, fetch must replay
//  gbpt_read_req_valid    out  1    to gbpt read_req_valid
//  update_valid           out  1    to gbpt update_valid (registered)
//  update_pc38            out  38   to gbpt update_pc38 (registered)
//  update_gh              out  9    to gbpt update_gh (registered)
//  update_taken           out  1    to gbpt update_taken (registered)
// BEHAVIOUR
//  Reset: queue empty, head/tail ptrs 0, starve_cnt 0, all update_* 0, enq_ready 1, fetch_read_stall 0.
//  Queue: circular FIFO; ptrs are log2(DEPTH)+1 bits (wrap bit). full = same index, different wrap bit. empty = ptrs equal.
//  enq fires = enq_valid & enq_ready; entry written at tail, tail++ at clock edge. No bypass: entry is visible the next cycle.
//  force = ~empty & ((starve_cnt == STARVE_MAX) | (full & enq_valid)).
//  drain = ~empty & (~fetch_read_req_valid | force).
//  gbpt_read_req_valid = fetch_read_req_valid & ~force; fetch_read_stall = fetch_read_req_valid & force (combinational).
//  On drain: head entry is loaded into update_* flops, update_valid <= 1, head++. Otherwise update_valid <= 0.
//    update_pc38/gh/taken hold their last value when update_valid is 0.
//  Latency: enq at cycle N, earliest drain decision at N+1, update_valid high at N+2.
//  Enq and drain in the same cycle are both legal. Count is unchanged; at full, enq_ready stays 0 that cycle (no full bypass).
//  starve_cnt: cleared on drain or when empty. Incremented when ~empty & fetch_read_req_valid & ~drain. Saturates at STARVE_MAX.
//  Updates issue strictly in commit order. No entry is dropped or duplicated.
//  Pointer wrap: DEPTH-1 -> 0 toggles the wrap bit. Back-to-back drains across the wrap are seamless.
//  Reset mid-operation: queued updates are discarded, update_valid drops asynchronously to 0, and nothing is replayed.
// TESTING
//  1 reset: nRST=0 with enq_valid=1 -> update_valid=0, enq_ready=1, fetch_read_stall=0. After release, the queue is empty.
//  2 idle drain: fetch idle; enq pc38=0x...0A8, gh=0x1F3, taken=1 at N -> update_valid=1 with same fields at N+2, one cycle only.
//  3 read priority/starve: queue 1 entry, fetch_read_req_valid held 1 -> no update for 8 cycles.
//    Cycle 9: fetch_read_stall=1, gbpt_read_req_valid=0. Next cycle update_valid=1 and starve_cnt=0.
//  4 full: fetch_read_req_valid held 1, enq 4 entries -> enq_ready=0. A 5th enq_valid forces drain the same cycle.
//    The 5th entry is accepted the following cycle.
//  5 ordering/wrap: 10 enqs with taken pattern 1010101010, fetch toggling 0/1 -> 10 updates in identical order.
//    Fields match exactly across the pointer wrap.
//  6 simultaneous enq+drain at count=2 for 6 cycles -> count stays 2, one update_valid per cycle, no loss.

Source files
------------

// File: rtl/gbpt_update_scheduler_if.sv
// Commit/fetch/gbpt-side signal bundle of the gbpt update scheduler.
// The master modport is the environment (commit, fetch, gbpt). The slave modport is the scheduler.
interface gbpt_update_scheduler_if;
   logic        enq_valid;
   logic        enq_ready;
   logic [37:0] enq_pc38;
   logic [8:0]  enq_gh;
   logic        enq_taken;
   logic        fetch_read_req_valid;
   logic        fetch_read_stall;
   logic        gbpt_read_req_valid;
   logic        update_valid;
   logic [37:0] update_pc38;
   logic [8:0]  update_gh;
   logic        update_taken;

   modport master (
      output enq_valid, enq_pc38, enq_gh, enq_taken, fetch_read_req_valid,
      input  enq_ready, fetch_read_stall, gbpt_read_req_valid,
      input  update_valid, update_pc38, update_gh, update_taken
   );

   modport slave (
      input  enq_valid, enq_pc38, enq_gh, enq_taken, fetch_read_req_valid,
      output enq_ready, fetch_read_stall, gbpt_read_req_valid,
      output update_valid, update_pc38, update_gh, update_taken
   );
endinterface

// File: rtl/gbpt_update_scheduler.sv
// Queues committed branch outcomes and drains them into the single-ported gbpt banks in cycles
// that fetch does not use, stealing a fetch read cycle on starvation or queue-full back-pressure.
module gbpt_update_scheduler #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input logic                     CLK,
   input logic                     nRST,
   gbpt_update_scheduler_if.slave  bus
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef logic [AW:0] ptr_t;
   typedef struct packed {
      logic [37:0] pc38;
      logic [8:0]  gh;
      logic        taken;
   } entry_t;

   entry_t        mem [DEPTH];
   ptr_t          head;
   ptr_t          tail;
   logic [CW-1:0] starve_cnt;
   entry_t        upd_entry;
   logic          upd_valid;

   logic empty;
   logic full;
   logic enq_fire;
   logic force_drain;
   logic drain;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty       = (head == tail);
   assign full        = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
   assign enq_fire    = bus.enq_valid && !full;
   assign force_drain = !empty && ((starve_cnt == STARVE_LIM) || (full && bus.enq_valid));
   assign drain       = !empty && (!bus.fetch_read_req_valid || force_drain);

   assign bus.enq_ready           = !full;
   assign bus.gbpt_read_req_valid = bus.fetch_read_req_valid && !force_drain;
   assign bus.fetch_read_stall    = bus.fetch_read_req_valid && force_drain;
   assign bus.update_valid        = upd_valid;
   assign bus.update_pc38         = upd_entry.pc38;
   assign bus.update_gh           = upd_entry.gh;
   assign bus.update_taken        = upd_entry.taken;

   // Storage needs no reset: occupancy is defined by the pointers alone.
   always_ff @(posedge CLK) begin
      if (enq_fire) begin
         mem[tail[AW-1:0]] <= '{pc38: bus.enq_pc38, gh: bus.enq_gh, taken: bus.enq_taken};
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head       <= '0;
         tail       <= '0;
         starve_cnt <= '0;
         upd_valid  <= 1'b0;
         upd_entry  <= '0;
      end else begin
         if (enq_fire) begin
            tail <= tail + ptr_t'(1);
         end
         if (drain) begin
            head      <= head + ptr_t'(1);
            upd_valid <= 1'b1;
            upd_entry <= mem[head[AW-1:0]];
         end else begin
            upd_valid <= 1'b0;
         end
         if (drain || empty) begin
            starve_cnt <= '0;
         end else if (bus.fetch_read_req_valid && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_gbpt_update_scheduler.sv
// Directed bench for gbpt_update_scheduler: cycle-exact control checks plus an in-order
// scoreboard of every accepted enqueue against every issued update.
module tb_gbpt_update_scheduler;
   localparam int unsigned DEPTH      = 4;
   localparam int unsigned STARVE_MAX = 8;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   gbpt_update_scheduler_if bus ();

   gbpt_update_scheduler #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   int          total   = 0;
   int          bad     = 0;
   int          upd_cnt = 0;
   logic [47:0] sb [$];

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Updates are compared before this cycle's enqueue is recorded (an entry needs two cycles).
   always @(negedge CLK) begin
      if (nRST) begin
         if (bus.update_valid) begin
            logic [47:0] exp_e;
            logic        have;
            upd_cnt++;
            have = (sb.size() != 0);
            check("update_expected", 48'(have), 48'(1));
            exp_e = have ? sb.pop_front() : 48'hx;
            if (have) begin
               check("update_fields", {bus.update_pc38, bus.update_gh, bus.update_taken}, exp_e);
            end
         end
         if (bus.enq_valid && bus.enq_ready) begin
            sb.push_back({bus.enq_pc38, bus.enq_gh, bus.enq_taken});
         end
      end
   end

   task automatic drive(input logic ev, input logic [37:0] pc, input logic [8:0] gh,
                        input logic tk, input logic frv);
      bus.enq_valid            = ev;
      bus.enq_pc38             = pc;
      bus.enq_gh               = gh;
      bus.enq_taken            = tk;
      bus.fetch_read_req_valid = frv;
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic drain_all();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (DEPTH + 4) next();
      check("drained_empty", 48'(sb.size()), 48'(0));
   endtask

   initial begin
      int          base;
      int          idx;
      int          guard;
      logic [37:0] pc;
      logic [8:0]  gh;
      logic        tk;

      // 1: reset holds outputs quiet even with a valid enqueue presented
      drive(1'b1, 38'h1234, 9'h055, 1'b1, 1'b1);
      mid();
      check("rst_update_valid", 48'(bus.update_valid), 48'(0));
      check("rst_enq_ready", 48'(bus.enq_ready), 48'(1));
      check("rst_stall", 48'(bus.fetch_read_stall), 48'(0));
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      nRST = 1'b1;
      next();
      mid();
      check("post_rst_stall", 48'(bus.fetch_read_stall), 48'(0));
      check("post_rst_gbpt_read", 48'(bus.gbpt_read_req_valid), 48'(1));
      next();
      mid();
      check("post_rst_update_valid", 48'(bus.update_valid), 48'(0));
      check("post_rst_sb_empty", 48'(sb.size()), 48'(0));

      // 2: idle drain latency and single-cycle pulse
      next();
      base = upd_cnt;
      drive(1'b1, 38'h00_0000_00A8, 9'h1F3, 1'b1, 1'b0);
      mid();
      check("idle_enq_ready", 48'(bus.enq_ready), 48'(1));
      next();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      mid();
      check("idle_n1_valid", 48'(bus.update_valid), 48'(0));
      next();
      mid();
      check("idle_n2_valid", 48'(bus.update_valid), 48'(1));
      check("idle_n2_fields", {bus.update_pc38, bus.update_gh, bus.update_taken},
            {38'h00_0000_00A8, 9'h1F3, 1'b1});
      next();
      mid();
      check("idle_n3_valid", 48'(bus.update_valid), 48'(0));
      check("idle_count", 48'(upd_cnt - base), 48'(1));
      next();

      // 3: fetch priority and starvation; second entry proves the counter restarted
      drive(1'b1, 38'h11_2222_3330, 9'h0A1, 1'b0, 1'b1);
      next();
      drive(1'b1, 38'h11_2222_3334, 9'h0A2, 1'b1, 1'b1);
      mid();
      check("starve_c1_stall", 48'(bus.fetch_read_stall), 48'(0));
      next();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 2; i <= 8; i++) begin
         mid();
         check("starve_wait_stall", 48'(bus.fetch_read_stall), 48'(0));
         check("starve_wait_valid", 48'(bus.update_valid), 48'(0));
         next();
      end
      mid();
      check("starve_c9_stall", 48'(bus.fetch_read_stall), 48'(1));
      check("starve_c9_gbpt_read", 48'(bus.gbpt_read_req_valid), 48'(0));
      next();
      mid();
      check("starve_c10_valid", 48'(bus.update_valid), 48'(1));
      check("starve_c10_stall", 48'(bus.fetch_read_stall), 48'(0));
      next();
      for (int i = 11; i <= 17; i++) begin
         mid();
         check("restarve_wait_stall", 48'(bus.fetch_read_stall), 48'(0));
         check("restarve_wait_valid", 48'(bus.update_valid), 48'(0));
         next();
      end
      mid();
      check("restarve_stall", 48'(bus.fetch_read_stall), 48'(1));
      next();
      mid();
      check("restarve_valid", 48'(bus.update_valid), 48'(1));
      next();
      mid();
      check("restarve_empty_stall", 48'(bus.fetch_read_stall), 48'(0));
      next();

      // 4: full queue with a waiting enqueue steals one fetch read
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 38'h20_0000_0000 + 38'(i * 8), 9'(i + 3), i[0], 1'b1);
         mid();
         check("full_fill_ready", 48'(bus.enq_ready), 48'(1));
         check("full_fill_stall", 48'(bus.fetch_read_stall), 48'(0));
         next();
      end
      drive(1'b1, 38'h20_0000_0100, 9'h1AA, 1'b1, 1'b1);
      mid();
      check("full_ready", 48'(bus.enq_ready), 48'(0));
      check("full_stall", 48'(bus.fetch_read_stall), 48'(1));
      check("full_gbpt_read", 48'(bus.gbpt_read_req_valid), 48'(0));
      next();
      mid();
      check("full_5th_ready", 48'(bus.enq_ready), 48'(1));
      check("full_5th_stall", 48'(bus.fetch_read_stall), 48'(0));
      check("full_drain_valid", 48'(bus.update_valid), 48'(1));
      next();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      mid();
      check("full_again_ready", 48'(bus.enq_ready), 48'(0));
      next();
      drain_all();

      // 5: ordering across pointer wrap with toggling fetch
      base  = upd_cnt;
      idx   = 0;
      guard = 0;
      while (idx < 10 && guard < 60) begin
         pc = {6'h2A, 32'h1000_0000 + 32'(idx * 4)};
         gh = 9'(idx * 37 + 5);
         tk = ~idx[0];
         drive(1'b1, pc, gh, tk, guard[0]);
         mid();
         if (bus.enq_ready) idx++;
         next();
         guard++;
      end
      check("wrap_all_enqueued", 48'(idx), 48'(10));
      drain_all();
      check("wrap_update_count", 48'(upd_cnt - base), 48'(10));

      // 6: steady enqueue plus drain at count two
      drive(1'b1, 38'h30_0000_0000, 9'h001, 1'b1, 1'b1);
      next();
      drive(1'b1, 38'h30_0000_0004, 9'h002, 1'b0, 1'b1);
      next();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 38'h30_0000_0008 + 38'(k * 4), 9'(k + 16), k[0], 1'b0);
         mid();
         check("steady_ready", 48'(bus.enq_ready), 48'(1));
         check("steady_valid", 48'(bus.update_valid), 48'(k != 0));
         next();
      end
      base = upd_cnt;
      drain_all();
      check("steady_residual", 48'(upd_cnt - base), 48'(3));

      // 7: reset mid-operation discards queued entries
      drive(1'b1, 38'h3F_0000_0000, 9'h111, 1'b1, 1'b1);
      next();
      drive(1'b1, 38'h3F_0000_0004, 9'h122, 1'b0, 1'b1);
      next();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      next();
      mid();
      check("mid_rst_pre_valid", 48'(bus.update_valid), 48'(1));
      #2;
      nRST = 1'b0;
      #1;
      check("mid_rst_valid_async", 48'(bus.update_valid), 48'(0));
      check("mid_rst_ready", 48'(bus.enq_ready), 48'(1));
      sb.delete();
      next();
      next();
      mid();
      nRST = 1'b1;
      base = upd_cnt;
      repeat (6) next();
      check("mid_rst_no_replay", 48'(upd_cnt - base), 48'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
